avr_ifetch: RTL and testbench
=============================

Name: avr_ifetch

Overview:
- Instruction-fetch stage directly upstream of the decoder; drives the 14-bit word address of the program ROM and consumes its 16-bit combinational read data.
- Holds the program counter and assembles two-word AVR instructions (CALL, JMP, LDS, STS) into a single packet.
- Presents packets to the decoder through a registered valid/ready output slot.
- Accepts PC redirects from execute for branches, calls, returns and skips.

Parameters:
- ADDR_W, 14, program-memory word-address width (16384 words).
- DATA_W, 16, instruction word width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; every flop is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  fetch enable; when low, the PC and FSM hold (SLEEP, halt).
- rom_addr  out  ADDR_W  ROM word address; equals the PC register.
- rom_data  in  DATA_W  ROM read data; combinational from rom_addr in the same cycle.
- redirect_valid  in  1  flush the stage and load a new PC.
- redirect_pc  in  ADDR_W  target PC for a redirect.
- out_valid  out  1  instruction packet valid.
- out_ready  in  1  decoder accepts the packet.
- out_instr  out  DATA_W  first instruction word.
- out_ext  out  DATA_W  second word (k/address); 0 for one-word instructions.
- out_two_word  out  1  packet is a two-word instruction.
- out_pc  out  ADDR_W  address of the first word.
- out_next_pc  out  ADDR_W  address following the instruction; this is the CALL/RCALL return address.

Behaviour:
- Reset (async assert, sync release): PC = RESET_PC; FSM = S_FETCH; out_valid = 0; out_instr, out_ext, out_pc, out_next_pc and out_two_word all 0; hold register = 0.
- load_en = fetch_en & (~out_valid | out_ready). The slot updates only when load_en is high; otherwise every output holds stable.
- Two-word detect (combinational on rom_data):
  - CALL: (w & 16'hFE0E) == 16'h940E
  - JMP: (w & 16'hFE0E) == 16'h940C
  - LDS: (w & 16'hFE0F) == 16'h9000
  - STS: (w & 16'hFE0F) == 16'h9200
- S_FETCH, load_en = 1, one-word instruction:
  - slot <= {rom_data, ext = 0, two_word = 0, pc = PC, next_pc = PC + 1}; out_valid <= 1; PC <= PC + 1.
- S_FETCH, load_en = 1, two-word instruction:
  - hold <= rom_data; hold_pc <= PC; PC <= PC + 1; out_valid <= 0; go to S_EXT.
- S_EXT, load_en = 1:
  - slot <= {hold, rom_data, two_word = 1, pc = hold_pc, next_pc = PC + 1}; out_valid <= 1; PC <= PC + 1; go to S_FETCH.
- load_en = 0: the FSM stays in its state and the PC holds.
- Throughput: one one-word instruction per cycle while out_ready = 1; a two-word instruction takes 2 cycles.
- Latency: ROM address to out_valid is 1 cycle for a one-word instruction, 2 cycles for a two-word instruction.
- Redirect has highest priority, regardless of fetch_en:
  - PC <= redirect_pc; FSM <= S_FETCH; out_valid <= 0; the hold register is discarded.
  - If out_ready is high in the same cycle, the current handshake still completes and the decoder owns that packet.
  - No new packet is produced in the redirect cycle.
- Wrap-around: PC arithmetic is modulo 2^ADDR_W. 16383 + 1 = 0, so a two-word instruction at 16383 takes its ext word from address 0, and its next_pc = 1.
- Reset mid-S_EXT: the partial instruction is dropped and fetch restarts at RESET_PC.
- An X in rom_data never reaches the FSM state: detect compares with masks, and any non-match is treated as one-word.

Optional Feature:
- Macro: AVR_IFETCH_PERF_EN.
- Defined:
  - Adds output perf_instr_cnt [31:0] and output perf_flush_cnt [15:0], both reset to 0.
  - perf_instr_cnt increments on every out_valid & out_ready handshake; it wraps at 2^32.
  - perf_flush_cnt increments on every redirect_valid cycle; it saturates at 16'hFFFF.
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

Decomposition:
- Package avr_core_pkg:
  - ADDR_W/DATA_W constants.
  - Two-word opcode mask/match constants for CALL, JMP, LDS, STS.
  - FSM state enum {S_FETCH, S_EXT}.
  - Fetch-packet struct {instr, ext, two_word, pc, next_pc}.
- Sub-module avr_twoword_detect: combinational, rom_data in, is_two_word out. The decoder reuses it for skip-length computation (CPSE/SBRC/SBRS/SBIC/SBIS).

Test Plan:
- Reset then release with ROM[0] = 0x0000 (NOP) and ROM[1] = 0x2C01 (MOV), out_ready = 1 -> rom_addr 0, 1, 2 on successive cycles; packets (instr 0x0000, pc 0) then (instr 0x2C01, pc 1), each with out_two_word = 0.
- ROM[5] = 0x940E, ROM[6] = 0x0123 (CALL 0x123), redirect to 5 -> after 2 cycles one packet: instr 0x940E, ext 0x0123, two_word 1, pc 5, next_pc 7.
- Hold out_ready = 0 for 3 cycles with a valid packet -> all outputs and rom_addr stable; PC advances again only on the cycle after out_ready rises.
- Redirect (redirect_pc = 0x0100) asserted while in S_EXT, with 0x9000 held from ROM[9] -> out_valid = 0 next cycle; rom_addr = 0x0100; no LDS packet is ever emitted.
- ROM[16383] = 0x940C, ROM[0] = 0x0040, redirect to 16383 -> packet pc 16383, ext 0x0040, next_pc 1.
- fetch_en = 0 for 4 cycles mid-stream -> PC and FSM frozen. With AVR_IFETCH_PERF_EN defined, perf_instr_cnt equals the handshake count exactly.

Source files
------------

// File: rtl/avr_core_pkg.sv
// Shared AVR core definitions: widths, two-word opcode patterns,
// fetch FSM state encoding and the fetch packet layout.
package avr_core_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  // Two-word instructions carry a 16-bit k/address in the following word
  localparam logic [15:0] CALL_MASK  = 16'hFE0E;
  localparam logic [15:0] CALL_MATCH = 16'h940E;
  localparam logic [15:0] JMP_MASK   = 16'hFE0E;
  localparam logic [15:0] JMP_MATCH  = 16'h940C;
  localparam logic [15:0] LDS_MASK   = 16'hFE0F;
  localparam logic [15:0] LDS_MATCH  = 16'h9000;
  localparam logic [15:0] STS_MASK   = 16'hFE0F;
  localparam logic [15:0] STS_MATCH  = 16'h9200;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXT   = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] ext;
    logic              two_word;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
  } fetch_pkt_t;

endpackage

// File: rtl/avr_twoword_detect.sv
// Flags CALL/JMP/LDS/STS first words. Also used by the decoder to size skips.
// Unknown input bits fall through the if-chain, so the flag resolves to 0.
module avr_twoword_detect
  import avr_core_pkg::*;
(
  input  logic [DATA_W-1:0] rom_data,
  output logic              is_two_word
);

  // Masked compare against each two-word opcode pattern
  always_comb begin
    is_two_word = 1'b0;
    if ((rom_data & CALL_MASK) == CALL_MATCH) is_two_word = 1'b1;
    if ((rom_data & JMP_MASK)  == JMP_MATCH)  is_two_word = 1'b1;
    if ((rom_data & LDS_MASK)  == LDS_MATCH)  is_two_word = 1'b1;
    if ((rom_data & STS_MASK)  == STS_MATCH)  is_two_word = 1'b1;
  end

endmodule

// File: rtl/avr_ifetch.sv
// AVR instruction fetch: program counter, two-word assembly and a
// registered valid/ready packet slot toward the decoder.
// Optional build macro AVR_IFETCH_PERF_EN adds handshake/flush counters.
//
// state   | meaning
// S_FETCH | rom_data is a first word; one-word goes straight to the slot
// S_EXT   | first word parked in hold; rom_data is the k/address word
module avr_ifetch #(
  parameter int                ADDR_W   = 14,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_ext,
  output logic              out_two_word,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_next_pc
`ifdef AVR_IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_instr_cnt,
  output logic [15:0]       perf_flush_cnt
`endif
);
  import avr_core_pkg::fetch_state_e;
  import avr_core_pkg::S_FETCH;
  import avr_core_pkg::S_EXT;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
  logic              valid_d, tw_d;
  logic [DATA_W-1:0] instr_d, ext_d;
  logic [ADDR_W-1:0] opc_d, npc_d;
  logic              is_two_word;
  logic              load_en;

  avr_twoword_detect u_detect (
    .rom_data    (rom_data),
    .is_two_word (is_two_word)
  );

  assign rom_addr = pc_q;
  assign pc_inc   = pc_q + 1'b1;
  assign load_en  = fetch_en & (~out_valid | out_ready);

  // Next state, next PC and slot contents; redirect overrides everything
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    hold_pc_d = hold_pc_q;
    valid_d   = out_valid;
    instr_d   = out_instr;
    ext_d     = out_ext;
    tw_d      = out_two_word;
    opc_d     = out_pc;
    npc_d     = out_next_pc;
    if (redirect_valid) begin
      pc_d      = redirect_pc;
      state_d   = S_FETCH;
      valid_d   = 1'b0;
      hold_d    = '0;
      hold_pc_d = '0;
    end else if (load_en) begin
      case (state_q)
        S_FETCH: begin
          pc_d = pc_inc;
          if (is_two_word) begin
            hold_d    = rom_data;
            hold_pc_d = pc_q;
            valid_d   = 1'b0;
            state_d   = S_EXT;
          end else begin
            instr_d = rom_data;
            ext_d   = '0;
            tw_d    = 1'b0;
            opc_d   = pc_q;
            npc_d   = pc_inc;
            valid_d = 1'b1;
          end
        end
        S_EXT: begin
          instr_d = hold_q;
          ext_d   = rom_data;
          tw_d    = 1'b1;
          opc_d   = hold_pc_q;
          npc_d   = pc_inc;
          valid_d = 1'b1;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // State, PC, hold and output slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      hold_q       <= '0;
      hold_pc_q    <= '0;
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_ext      <= '0;
      out_two_word <= 1'b0;
      out_pc       <= '0;
      out_next_pc  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_q       <= hold_d;
      hold_pc_q    <= hold_pc_d;
      out_valid    <= valid_d;
      out_instr    <= instr_d;
      out_ext      <= ext_d;
      out_two_word <= tw_d;
      out_pc       <= opc_d;
      out_next_pc  <= npc_d;
    end
  end

`ifdef AVR_IFETCH_PERF_EN
  // Handshake counter wraps; flush counter sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_instr_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (out_valid && out_ready) perf_instr_cnt <= perf_instr_cnt + 32'd1;
      if (redirect_valid && (perf_flush_cnt != 16'hFFFF))
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_avr_ifetch.sv
// Bench for avr_ifetch: ROM model, scoreboard of architectural packets,
// directed timing checks around redirect, stall, freeze and wrap.
module tb_avr_ifetch;
  import avr_core_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fetch_en = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_instr, out_ext;
  logic              out_two_word;
  logic [ADDR_W-1:0] out_pc, out_next_pc;
`ifdef AVR_IFETCH_PERF_EN
  logic [31:0]       perf_instr_cnt;
  logic [15:0]       perf_flush_cnt;
`endif

  logic [15:0] rom [0:16383];
  assign rom_data = rom[rom_addr];

  avr_ifetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_ext        (out_ext),
    .out_two_word   (out_two_word),
    .out_pc         (out_pc),
    .out_next_pc    (out_next_pc)
`ifdef AVR_IFETCH_PERF_EN
    ,
    .perf_instr_cnt (perf_instr_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  int fl_cnt = 0;
  fetch_pkt_t sb_q[$];
  fetch_pkt_t mon_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Architectural view of the first-word opcodes that need a second word
  function automatic logic tw(input logic [15:0] w);
    return ((w[15:9] == 7'b1001010) && (w[3:2] == 2'b11)) ||
           ((w[15:10] == 6'b100100) && (w[3:0] == 4'b0000));
  endfunction

  task automatic push_stream(input logic [ADDR_W-1:0] start, input int n);
    logic [ADDR_W-1:0] p;
    fetch_pkt_t e;
    p = start;
    for (int i = 0; i < n; i++) begin
      e.instr = rom[p];
      e.pc    = p;
      if (tw(rom[p])) begin
        e.ext      = rom[p + 14'd1];
        e.two_word = 1'b1;
        e.next_pc  = p + 14'd2;
      end else begin
        e.ext      = '0;
        e.two_word = 1'b0;
        e.next_pc  = p + 14'd1;
      end
      sb_q.push_back(e);
      p = e.next_pc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [ADDR_W-1:0] t, input int n);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    tick();
    redirect_valid = 1'b0;
    sb_q.delete();
    push_stream(t, n);
  endtask

  // Compare each accepted packet against the expected stream
  always @(negedge clk) begin
    if (!rst_n) begin
      hs_cnt = 0;
      fl_cnt = 0;
    end else begin
      if (redirect_valid) fl_cnt++;
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'(out_pc), 32'hFFFF_FFFF);
        end else begin
          mon_e = sb_q.pop_front();
          chk("pkt_instr",   32'(out_instr),    32'(mon_e.instr));
          chk("pkt_ext",     32'(out_ext),      32'(mon_e.ext));
          chk("pkt_tw",      32'(out_two_word), 32'(mon_e.two_word));
          chk("pkt_pc",      32'(out_pc),       32'(mon_e.pc));
          chk("pkt_next_pc", 32'(out_next_pc),  32'(mon_e.next_pc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) rom[i] = 16'h0000;
    rom[1]     = 16'h2C01;
    rom[5]     = 16'h940E;
    rom[6]     = 16'h0123;
    rom[9]     = 16'h9000;
    rom[10]    = 16'h1234;
    rom[16383] = 16'h940C;
    for (int i = 16'h200; i < 16'h240; i++) begin
      case ($urandom_range(0, 5))
        0: rom[i] = 16'h940E | (16'($urandom) & 16'h01F1);
        1: rom[i] = 16'h940C | (16'($urandom) & 16'h01F1);
        2: rom[i] = 16'h9000 | (16'($urandom) & 16'h01F0);
        3: rom[i] = 16'h9200 | (16'($urandom) & 16'h01F0);
        default: rom[i] = 16'($urandom);
      endcase
    end

    // reset state
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid",   32'(out_valid),    32'd0);
    chk("rst_addr",    32'(rom_addr),     32'd0);
    chk("rst_instr",   32'(out_instr),    32'd0);
    chk("rst_ext",     32'(out_ext),      32'd0);
    chk("rst_tw",      32'(out_two_word), 32'd0);
    chk("rst_pc",      32'(out_pc),       32'd0);
    chk("rst_next_pc", 32'(out_next_pc),  32'd0);

    // straight-line fetch after release
    push_stream(14'd0, 8);
    rst_n = 1'b1;
    chk("start_addr0", 32'(rom_addr), 32'd0);
    @(negedge clk);
    chk("start_addr1", 32'(rom_addr), 32'd1);
    chk("start_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("start_addr2", 32'(rom_addr), 32'd2);

    // CALL at 5: two cycles to the packet
    tick();
    do_redirect(14'd5, 4);
    @(negedge clk);
    chk("call_flush", 32'(out_valid), 32'd0);
    chk("call_addr5", 32'(rom_addr), 32'd5);
    tick();
    @(negedge clk);
    chk("call_wait", 32'(out_valid), 32'd0);
    chk("call_addr6", 32'(rom_addr), 32'd6);
    tick();
    @(negedge clk);
    chk("call_valid", 32'(out_valid), 32'd1);
    chk("call_tw",    32'(out_two_word), 32'd1);
    chk("call_npc",   32'(out_next_pc), 32'd7);
    chk("call_addr7", 32'(rom_addr), 32'd7);

    // backpressure stall
    tick();
    do_redirect(14'h020, 6);
    tick();
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_pc",    32'(out_pc), 32'h20);
      chk("stall_addr",  32'(rom_addr), 32'h21);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_rel_addr", 32'(rom_addr), 32'h21);
    tick();
    @(negedge clk);
    chk("stall_adv_addr", 32'(rom_addr), 32'h22);
    chk("stall_adv_pc",   32'(out_pc), 32'h21);

    // redirect while LDS first word is held
    tick();
    do_redirect(14'd9, 4);
    tick();
    chk("lds_ext_wait", 32'(out_valid), 32'd0);
    do_redirect(14'h100, 4);
    @(negedge clk);
    chk("lds_drop_valid", 32'(out_valid), 32'd0);
    chk("lds_drop_addr",  32'(rom_addr), 32'h100);
    tick();
    tick();

    // fetch_en low while in S_EXT
    do_redirect(14'd5, 4);
    tick();
    fetch_en = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("frz_addr",  32'(rom_addr), 32'd6);
      chk("frz_valid", 32'(out_valid), 32'd0);
      tick();
    end
    fetch_en = 1'b1;
    @(negedge clk);
    chk("frz_rel_addr", 32'(rom_addr), 32'd6);
    tick();
    @(negedge clk);
    chk("frz_pkt_valid", 32'(out_valid), 32'd1);
    chk("frz_pkt_pc",    32'(out_pc), 32'd5);
    chk("frz_pkt_ext",   32'(out_ext), 32'h0123);

    // JMP at the top of memory takes its ext word from address 0
    rom[0] = 16'h0040;
    tick();
    do_redirect(14'h3FFF, 4);
    @(negedge clk);
    chk("wrap_addr_top", 32'(rom_addr), 32'h3FFF);
    tick();
    @(negedge clk);
    chk("wrap_addr0", 32'(rom_addr), 32'd0);
    tick();
    @(negedge clk);
    chk("wrap_pc",   32'(out_pc), 32'h3FFF);
    chk("wrap_npc",  32'(out_next_pc), 32'd1);
    chk("wrap_ext",  32'(out_ext), 32'h0040);
    chk("wrap_addr1", 32'(rom_addr), 32'd1);

    // reset while in S_EXT drops the partial CALL
    tick();
    do_redirect(14'd5, 4);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ext_addr",  32'(rom_addr), 32'd0);
    chk("rst_ext_valid", 32'(out_valid), 32'd0);
    sb_q.delete();
    push_stream(14'd0, 8);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_ext_pkt_pc",    32'(out_pc), 32'd0);
    chk("rst_ext_pkt_instr", 32'(out_instr), 32'h0040);

    // random program region with random backpressure and a mid-run redirect
    tick();
    do_redirect(14'h200, 80);
    for (int c = 0; c < 40; c++) begin
      if (c == 20) begin
        out_ready = 1'b1;
        do_redirect(14'h210, 60);
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end

    out_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
`ifdef AVR_IFETCH_PERF_EN
    chk("perf_instr", perf_instr_cnt, 32'(hs_cnt));
    chk("perf_flush", 32'(perf_flush_cnt), 32'(fl_cnt));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
